// File: rtl/riscv_decode_stage_if.sv
// Fetch-to-issue bundle for the decode stage. Signal suffixes follow the
// decode stage's point of view (slave side).
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holding valid high keeps its
// payload stable until that edge; ready may be low while valid is high.
interface riscv_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     in_instr_i;
    logic [XLEN-1:0] in_pc_i;

    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] out_pc_o;
    logic [6:0]      out_opcode_o;
    logic [3:0]      out_format_o;
    logic [4:0]      out_rd_o;
    logic [4:0]      out_rs1_o;
    logic [4:0]      out_rs2_o;
    logic [2:0]      out_funct3_o;
    logic [6:0]      out_funct7_o;
    logic [XLEN-1:0] out_imm_o;
    logic            out_illegal_o;

    // Decode stage view
    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_format_o,
               out_rd_o, out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o,
               out_imm_o, out_illegal_o
    );

    // Fetch/issue (environment) view
    modport master (
        output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_opcode_o, out_format_o,
               out_rd_o, out_rs1_o, out_rs2_o, out_funct3_o, out_funct7_o,
               out_imm_o, out_illegal_o
    );
endinterface

// File: rtl/riscv_decode_stage.sv
// RV32/RV64 decode stage: combinational field/immediate/legality decode of
// the incoming word, captured into a 2-entry skid buffer so that in_ready_o
// can be a flop while still sustaining one instruction per cycle.
module riscv_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter bit ENABLE_A = 1'b1,
    parameter bit ENABLE_F = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    riscv_decode_stage_if.slave bus,
    output logic [CNT_W-1:0]    illegal_cnt_o
);

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_OP_IMM32 = 7'h1B;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_STORE_FP = 7'h27;
    localparam logic [6:0] OPC_AMO      = 7'h2F;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_OP32     = 7'h3B;
    localparam logic [6:0] OPC_MADD     = 7'h43;
    localparam logic [6:0] OPC_MSUB     = 7'h47;
    localparam logic [6:0] OPC_NMSUB    = 7'h4B;
    localparam logic [6:0] OPC_NMADD    = 7'h4F;
    localparam logic [6:0] OPC_OP_FP    = 7'h53;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    localparam logic [3:0] FMT_UNK = 4'd0;
    localparam logic [3:0] FMT_R   = 4'd1;
    localparam logic [3:0] FMT_I   = 4'd2;
    localparam logic [3:0] FMT_S   = 4'd3;
    localparam logic [3:0] FMT_U   = 4'd4;
    localparam logic [3:0] FMT_B   = 4'd5;
    localparam logic [3:0] FMT_J   = 4'd6;
    localparam logic [3:0] FMT_A   = 4'd7;
    localparam logic [3:0] FMT_F   = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [3:0]      fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    logic [31:0] instr;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [3:0]  fmt;
    logic [63:0] imm64;
    logic        is_op;
    logic        illegal;
    entry_t      dec;

    entry_t      ent0_q, ent0_d;   // head
    entry_t      ent1_q, ent1_d;   // second in line
    logic [1:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic        push, pop;

    assign instr = bus.in_instr_i;
    assign opc   = instr[6:0];
    assign f7    = instr[31:25];
    assign is_op = (opc == OPC_OP) || (opc == OPC_OP32);

    // Opcode to instruction format
    always_comb begin
        fmt = FMT_UNK;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_OP_IMM32,
            OPC_SYSTEM, OPC_MISC_MEM, OPC_LOAD_FP:         fmt = FMT_I;
            OPC_STORE, OPC_STORE_FP:                       fmt = FMT_S;
            OPC_BRANCH:                                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                            fmt = FMT_U;
            OPC_JAL:                                       fmt = FMT_J;
            OPC_OP, OPC_OP32:                              fmt = FMT_R;
            OPC_AMO:                                       fmt = FMT_A;
            OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD,
            OPC_OP_FP:                                     fmt = FMT_F;
            default:                                       fmt = FMT_UNK;
        endcase
    end

    // Immediate built at 64 bits and truncated, so XLEN=32 needs no special case
    always_comb begin
        imm64 = 64'd0;
        case (fmt)
            FMT_I: imm64 = {{52{instr[31]}}, instr[31:20]};
            FMT_S: imm64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U: imm64 = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_J: imm64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm64 = 64'd0;
        endcase
    end

    // Legality against the enabled extension set
    always_comb begin
        illegal = 1'b0;
        if (instr[1:0] != 2'b11)                                   illegal = 1'b1;
        if (fmt == FMT_UNK)                                        illegal = 1'b1;
        if ((XLEN == 32) && ((opc == OPC_OP32) || (opc == OPC_OP_IMM32)))
                                                                   illegal = 1'b1;
        if ((opc == OPC_AMO) && !ENABLE_A)                         illegal = 1'b1;
        if (((fmt == FMT_F) || (opc == OPC_LOAD_FP) || (opc == OPC_STORE_FP))
            && !ENABLE_F)                                          illegal = 1'b1;
        if (is_op && (f7 == 7'b0000001) && !ENABLE_M)              illegal = 1'b1;
        if (is_op && !((f7 == 7'b0000000) || (f7 == 7'b0100000) ||
                       (f7 == 7'b0000001)))                        illegal = 1'b1;
    end

    // Pack the decoded fields into a buffer entry
    always_comb begin
        dec.pc      = bus.in_pc_i;
        dec.opcode  = opc;
        dec.fmt     = fmt;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct3  = instr[14:12];
        dec.funct7  = f7;
        dec.imm     = imm64[XLEN-1:0];
        dec.illegal = illegal;
    end

    // A flush kills the incoming word; the outgoing one still completes
    assign push = bus.in_valid_i && in_ready_q && !flush_i;
    assign pop  = (cnt_q != 2'd0) && bus.out_ready_i;

    // Skid buffer next state: entry 0 is always the head
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        ent0_d = dec;
                        cnt_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = dec;
                    end else if (push) begin
                        ent1_d = dec;
                        cnt_d  = 2'd2;
                    end else if (pop) begin
                        cnt_d  = 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen
                    if (pop) begin
                        ent0_d = ent1_q;
                        cnt_d  = 2'd1;
                    end
                end
            endcase
        end
        in_ready_d = (cnt_d != 2'd2);
    end

    // Saturating count of illegal entries handed to the consumer
    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (pop && ent0_q.illegal && !(&ill_cnt_q))
            ill_cnt_d = ill_cnt_q + 1'b1;
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
            ill_cnt_q  <= '0;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign bus.in_ready_o    = in_ready_q;
    assign bus.out_valid_o   = (cnt_q != 2'd0);
    assign bus.out_pc_o      = ent0_q.pc;
    assign bus.out_opcode_o  = ent0_q.opcode;
    assign bus.out_format_o  = ent0_q.fmt;
    assign bus.out_rd_o      = ent0_q.rd;
    assign bus.out_rs1_o     = ent0_q.rs1;
    assign bus.out_rs2_o     = ent0_q.rs2;
    assign bus.out_funct3_o  = ent0_q.funct3;
    assign bus.out_funct7_o  = ent0_q.funct7;
    assign bus.out_imm_o     = ent0_q.imm;
    assign bus.out_illegal_o = ent0_q.illegal;
    assign illegal_cnt_o     = ill_cnt_q;

endmodule

// File: doc/riscv_decode_stage.md
Name: riscv_decode_stage

Overview:
- Registered, parametrised RV32/RV64 instruction decode stage with valid/ready handshake on both sides.
- Sits between fetch and issue.
- Classifies each 32-bit instruction word into its format and extracts rd/rs1/rs2/funct3/funct7, plus the XLEN-wide sign-extended immediate.
- Flags illegal encodings against the enabled extension set and keeps a saturating illegal-instruction counter.
- A 2-entry skid buffer gives full throughput with a registered in_ready_o.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- ENABLE_M, 1, accept M-extension ops (OP/OP32 with funct7=0000001).
- ENABLE_A, 1, accept OPCODE_AMO.
- ENABLE_F, 0, accept LOAD_FP/STORE_FP/MADD/MSUB/NMSUB/NMADD/OP_FP.
- CNT_W, 16, illegal counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush; drops all buffered entries
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  stage can accept
- in_instr_i  in  32  raw instruction
- in_pc_i  in  XLEN  instruction address
- out_valid_o  out  1  decoded entry valid
- out_ready_i  in  1  consumer accepts
- out_pc_o  out  XLEN  passthrough PC
- out_opcode_o  out  7  instr[6:0]
- out_format_o  out  4  0=Unknown,1=R,2=I,3=S,4=U,5=B,6=J,7=A,8=F
- out_rd_o / out_rs1_o / out_rs2_o  out  5 each  register fields (instr[11:7], [19:15], [24:20])
- out_funct3_o  out  3  instr[14:12]
- out_funct7_o  out  7  instr[31:25]
- out_imm_o  out  XLEN  sign-extended immediate; 0 for R/A/F/Unknown
- out_illegal_o  out  1  illegal encoding
- illegal_cnt_o  out  CNT_W  saturating count of illegal entries delivered

Behaviour:
- Reset (async, rst_ni=0):
  - Buffer empty; out_valid_o=0; in_ready_o=1; illegal_cnt_o=0.
  - All data outputs 0.
- Decode is combinational on in_instr_i. The result is written into the buffer on the in handshake (in_valid_i & in_ready_o).
- Latency is 1 cycle: an instruction accepted in cycle N is presented in cycle N+1 if the buffer was empty.
- Skid buffer:
  - Two entries, FIFO order, occupancy 0..2.
  - in_ready_o is registered and equals (occupancy<2) at the next edge. It deasserts only when the buffer becomes full.
  - Input push while full cannot occur.
  - Same-cycle push and pop: occupancy unchanged, order preserved.
  - out_valid_o = occupancy>0. Outputs are the head entry and stay stable while out_valid_o & !out_ready_i.
- Format map by opcode:
  - I: LOAD, OP_IMM, JALR, OP_IMM32, SYSTEM, MISC_MEM, LOAD_FP.
  - S: STORE, STORE_FP.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - R: OP, OP32.
  - A: AMO.
  - F: MADD, MSUB, NMSUB, NMADD, OP_FP.
  - Others: Unknown.
- Immediates (sign bit instr[31], extended to XLEN):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Illegal if any of the following holds:
  - instr[1:0]≠11.
  - Format Unknown.
  - OP32/OP_IMM32 while XLEN=32.
  - AMO while !ENABLE_A.
  - F format, LOAD_FP or STORE_FP while !ENABLE_F.
  - funct7=0000001 on OP/OP32 while !ENABLE_M.
  - On OP/OP32: funct7 not in {0000000, 0100000, 0000001}.
- On an illegal entry, format, fields and immediate are still reported as decoded; consumers qualify them with out_illegal_o.
- illegal_cnt_o increments by 1 on each output handshake with out_illegal_o=1. It saturates at all-ones and is not cleared by flush_i.
- flush_i:
  - Next edge: occupancy=0, out_valid_o=0, in_ready_o=1.
  - An input handshake in the same cycle is discarded.
  - An output handshake in the same cycle still counts toward illegal_cnt_o.
- Reset mid-transfer discards all entries immediately (asynchronous).

Test Plan:
- Push 0xFFF00093 (addi x1,x0,-1), out_ready_i=1 -> next cycle: format=2, rd=1, rs1=0, imm=all ones, illegal=0.
- Push 0xFE000EE3 (beq x0,x0,-4) -> format=5, imm=-4 (0xFFFFFFFC for XLEN=32); push 0x0000006F -> format=6, imm=0.
- Push 0x123452B7 (lui x5) -> format=4, rd=5, imm=0x12345000. With XLEN=64: push 0x800000B7 (lui x1, 0x80000) -> imm=0xFFFFFFFF80000000.
- XLEN=32: push 0x0000003B (addw), then 0x00000001 -> both illegal=1; illegal_cnt_o=2 after both are consumed. Preload counter to max -> stays at max.
- Backpressure: out_ready_i=0, stream 3 instructions -> in_ready_o drops after 2 accepted; then out_ready_i=1 -> same 3 emerge in order, one per cycle, with no loss.
- Buffer full, assert flush_i together with in_valid_i -> next cycle out_valid_o=0, in_ready_o=1, flushed input never appears. Pulse rst_ni low mid-stream -> outputs 0, counter 0.
